// File: rtl/lif_neuron_layer.sv
// Leaky integrate-and-fire layer: serially loaded signed weights, one shared
// leak/accumulate/fire sequencer driving an array of per-neuron datapaths.

module lif_neuron #(
   parameter int V_BITS     = 8,
   parameter int W_BITS     = 4,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     leak_i,
   input  logic                     acc_i,
   input  logic                     fire_i,
   input  logic signed [W_BITS-1:0] w_i,
   input  logic signed [V_BITS-1:0] thr_i,
   output logic signed [V_BITS-1:0] v_o,
   output logic                     spike_o
);
   localparam int R_BITS = $clog2(REFRAC + 2);
   localparam logic [V_BITS-1:0] V_MAX = {1'b0, {(V_BITS-1){1'b1}}};
   localparam logic [V_BITS-1:0] V_MIN = {1'b1, {(V_BITS-1){1'b0}}};

   logic signed [V_BITS-1:0] v_q, v_d;
   logic [R_BITS-1:0]        ref_q, ref_d;
   logic                     spk_q, spk_d;
   logic [V_BITS:0]          sum;

   always_comb begin
      v_d   = v_q;
      ref_d = ref_q;
      spk_d = spk_q;
      // one guard bit so overflow shows up as disagreeing top bits
      sum   = {v_q[V_BITS-1], v_q} + {{(V_BITS+1-W_BITS){w_i[W_BITS-1]}}, w_i};
      if (ref_q == '0) begin
         if (leak_i)
            v_d = v_q - (v_q >>> LEAK_SHIFT);
         else if (acc_i)
            v_d = (sum[V_BITS] != sum[V_BITS-1]) ? (sum[V_BITS] ? V_MIN : V_MAX)
                                                  : sum[V_BITS-1:0];
      end
      if (fire_i) begin
         if (ref_q != '0) begin
            ref_d = ref_q - R_BITS'(1);
            spk_d = 1'b0;
         end else if (v_q >= thr_i) begin
            spk_d = 1'b1;
            v_d   = '0;
            ref_d = R_BITS'(REFRAC);
         end else begin
            spk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         ref_q <= '0;
         spk_q <= 1'b0;
      end else begin
         v_q   <= v_d;
         ref_q <= ref_d;
         spk_q <= spk_d;
      end
   end

   assign v_o     = v_q;
   assign spike_o = spk_q;
endmodule

module lif_neuron_layer #(
   parameter int N_IN       = 8,
   parameter int N_OUT      = 4,
   parameter int W_BITS     = 4,
   parameter int V_BITS     = 8,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   localparam int SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_IN-1:0]   spike_in,
   input  logic              step,
   input  logic [V_BITS-2:0] thr,
   input  logic              cfg_en,
   input  logic              cfg_bit,
   input  logic [SEL_W-1:0]  vmem_sel,
   output logic [N_OUT-1:0]  spike_out,
   output logic              busy,
   output logic [V_BITS-1:0] vmem_out
);
   localparam int CHAIN_W = N_IN * N_OUT * W_BITS;
   localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

   typedef enum logic [1:0] {IDLE, LEAK, ACCUM, FIRE} state_t;
   typedef logic [N_OUT-1:0][N_IN-1:0][W_BITS-1:0] wmat_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [N_IN-1:0]         spk_q, spk_d;
   logic                    busy_q, busy_d;
   logic [CHAIN_W-1:0]      chain_q, chain_d;
   wmat_t                   wmat;
   logic [N_OUT-1:0][V_BITS-1:0] v_all;
   logic                    leak_en, acc_en, fire_en;
   logic signed [V_BITS-1:0] thr_s;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      spk_d   = spk_q;
      busy_d  = busy_q;
      chain_d = chain_q;
      case (state_q)
         IDLE: begin
            // configuration has priority; a coincident step is dropped
            if (cfg_en)
               chain_d = {cfg_bit, chain_q[CHAIN_W-1:1]};
            else if (step) begin
               spk_d   = spike_in;
               busy_d  = 1'b1;
               state_d = LEAK;
            end
         end
         LEAK: begin
            idx_d   = '0;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (idx_q == IDX_W'(N_IN - 1)) state_d = FIRE;
            else                           idx_d   = idx_q + IDX_W'(1);
         end
         FIRE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         spk_q   <= '0;
         busy_q  <= 1'b0;
         chain_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         spk_q   <= spk_d;
         busy_q  <= busy_d;
         chain_q <= chain_d;
      end
   end

   assign wmat    = chain_q;
   assign leak_en = (state_q == LEAK);
   assign acc_en  = (state_q == ACCUM) && spk_q[idx_q];
   assign fire_en = (state_q == FIRE);
   assign thr_s   = {1'b0, thr};

   for (genvar n = 0; n < N_OUT; n++) begin : g_nrn
      lif_neuron #(
         .V_BITS(V_BITS), .W_BITS(W_BITS), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
      ) u_nrn (
         .clk    (clk),
         .rst_n  (rst_n),
         .leak_i (leak_en),
         .acc_i  (acc_en),
         .fire_i (fire_en),
         .w_i    (wmat[n][idx_q]),
         .thr_i  (thr_s),
         .v_o    (v_all[n]),
         .spike_o(spike_out[n])
      );
   end

   assign busy     = busy_q;
   assign vmem_out = v_all[vmem_sel];
endmodule

// File: tb/tb_lif_neuron_layer.sv
// Bench for lif_neuron_layer: table of timesteps with a scoreboard queue,
// plus hand sequences for busy-time interference and mid-timestep reset.

module tb_lif_neuron_layer;
   localparam int N_IN = 8, N_OUT = 4, V_BITS = 8, CHAIN_W = 128;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [N_IN-1:0]   spike_in = '0;
   logic              step = 1'b0;
   logic [V_BITS-2:0] thr = '0;
   logic              cfg_en = 1'b0;
   logic              cfg_bit = 1'b0;
   logic [1:0]        vmem_sel = '0;
   logic [N_OUT-1:0]  spike_out;
   logic              busy;
   logic [V_BITS-1:0] vmem_out;

   lif_neuron_layer dut (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .step(step), .thr(thr),
      .cfg_en(cfg_en), .cfg_bit(cfg_bit), .vmem_sel(vmem_sel),
      .spike_out(spike_out), .busy(busy), .vmem_out(vmem_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               phase;
      logic [7:0]       spk;
      logic [6:0]       th;
      logic [1:0]       sel;
      logic [3:0]       exp_spike;
      logic [7:0]       exp_v;
   } vec_t;

   typedef struct {
      logic [3:0] spike;
      logic [1:0] sel;
      logic [7:0] v;
   } exp_t;

   vec_t               tbl[16];
   logic [CHAIN_W-1:0] chains[4];
   exp_t               sb[$];
   int                 n_cmp = 0;
   int                 n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; step = 1'b0; cfg_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [CHAIN_W-1:0] c);
      for (int i = 0; i < CHAIN_W; i++) begin
         @(negedge clk);
         cfg_en = 1'b1; cfg_bit = c[i];
      end
      @(negedge clk);
      cfg_en = 1'b0;
   endtask

   // pulse step for one edge, then count edges until busy drops
   task automatic run_step(input logic [7:0] spk, input string name);
      int lat;
      @(negedge clk);
      step = 1'b1; spike_in = spk;
      @(negedge clk);
      step = 1'b0;
      lat = 0;
      while (busy === 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, N_IN + 2);
   endtask

   initial begin
      chains[0] = '0;
      chains[1] = 128'h0000_0000_0000_0000_0000_0000_3333_3333;
      chains[2] = 128'h0000_0000_0000_0000_0000_0007_0000_0000;
      chains[3] = 128'h0000_0000_8888_8888_0000_0000_0000_0000;

      //         phase spk    thr   sel  spike    v
      tbl[0]  = '{0, 8'hFF, 7'd1,   0, 4'b0000, 8'h00};
      tbl[1]  = '{1, 8'hFF, 7'd10,  0, 4'b0001, 8'h00};
      tbl[2]  = '{1, 8'hFF, 7'd10,  0, 4'b0000, 8'h00};
      tbl[3]  = '{1, 8'hFF, 7'd10,  0, 4'b0000, 8'h00};
      tbl[4]  = '{1, 8'hFF, 7'd10,  0, 4'b0001, 8'h00};
      tbl[5]  = '{2, 8'h01, 7'd100, 1, 4'b0000, 8'h07};
      tbl[6]  = '{2, 8'h01, 7'd100, 1, 4'b0000, 8'h0E};
      tbl[7]  = '{2, 8'h00, 7'd100, 1, 4'b0000, 8'h0D};
      tbl[8]  = '{2, 8'h00, 7'd12,  1, 4'b0010, 8'h00};
      tbl[9]  = '{3, 8'hFF, 7'd100, 2, 4'b0000, 8'hC0};
      tbl[10] = '{3, 8'hFF, 7'd100, 2, 4'b0000, 8'h88};
      tbl[11] = '{3, 8'hFF, 7'd100, 2, 4'b0000, 8'h80};
      tbl[12] = '{3, 8'h00, 7'd0,   2, 4'b1011, 8'h90};
      tbl[13] = '{3, 8'hFF, 7'd100, 3, 4'b0000, 8'h00};
      tbl[14] = '{2, 8'h01, 7'd100, 1, 4'b0000, 8'h07};
      tbl[15] = '{2, 8'h00, 7'd100, 0, 4'b0000, 8'h00};

      // reset state
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_spike", spike_out, 0);
      for (int s = 0; s < N_OUT; s++) begin
         vmem_sel = s[1:0];
         #1;
         chk($sformatf("rst_vmem%0d", s), vmem_out, 0);
      end

      for (int i = 0; i < 16; i++) begin
         exp_t e;
         if (i == 0 || tbl[i].phase != tbl[i-1].phase) begin
            do_reset();
            load(chains[tbl[i].phase]);
         end
         thr = tbl[i].th;
         sb.push_back('{tbl[i].exp_spike, tbl[i].sel, tbl[i].exp_v});
         run_step(tbl[i].spk, $sformatf("vec%0d", i));
         e = sb.pop_front();
         vmem_sel = e.sel;
         #1;
         chk($sformatf("vec%0d_spike", i), spike_out, e.spike);
         chk($sformatf("vec%0d_vmem", i), vmem_out, e.v);
      end

      // step and cfg while busy are ignored
      do_reset();
      load(chains[2]);
      thr = 7'd100;
      vmem_sel = 2'd1;
      @(negedge clk);
      step = 1'b1; spike_in = 8'h01;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      step = 1'b1; spike_in = 8'hFF; cfg_en = 1'b1; cfg_bit = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0; cfg_en = 1'b0;
      for (int c = 0; c < 40 && busy === 1'b1; c++) @(negedge clk);
      chk("busyE_drop", busy, 0);
      repeat (3) @(negedge clk);
      chk("busyE_no_requeue", busy, 0);
      chk("busyE_v1", vmem_out, 8'h07);
      run_step(8'h01, "busyE_w");
      chk("busyE_w_unchanged", vmem_out, 8'h0E);

      // step with cfg_en in IDLE: one bit shifted, no timestep
      @(negedge clk);
      step = 1'b1; cfg_en = 1'b1; cfg_bit = 1'b0; spike_in = 8'hFF;
      @(negedge clk);
      step = 1'b0; cfg_en = 1'b0;
      chk("cfgwin_busy", busy, 0);
      run_step(8'h81, "cfgwin");
      vmem_sel = 2'd1;
      #1;
      chk("cfgwin_v1", vmem_out, 8'h10);
      vmem_sel = 2'd0;
      #1;
      chk("cfgwin_v0", vmem_out, 8'hF8);

      // async reset in the middle of ACCUM
      do_reset();
      load(128'h0000_0000_0000_0000_1111_1111_3333_3333);
      thr = 7'd10;
      run_step(8'hFF, "rstF_a");
      chk("rstF_a_spike", spike_out, 4'b0001);
      @(negedge clk);
      step = 1'b1; spike_in = 8'hFF;
      @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
      vmem_sel = 2'd1;
      #1;
      chk("rstF_mid_v1", vmem_out, 8'h0B);
      chk("rstF_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rstF_busy", busy, 0);
      chk("rstF_spike", spike_out, 0);
      chk("rstF_v1", vmem_out, 0);
      vmem_sel = 2'd0;
      #1;
      chk("rstF_v0", vmem_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_step(8'hFF, "rstF_b");
      chk("rstF_fresh_spike", spike_out, 0);
      chk("rstF_fresh_v0", vmem_out, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lif_neuron_layer.md
Name: lif_neuron_layer

Overview:
Leaky integrate-and-fire layer for the tinysnn design: N_OUT neurons, each fully connected to N_IN binary input spikes through signed serially-loaded weights. It sits directly upstream of the TinyTapeout top-level I/O wrapper. The top drives `spike_in`/`step` from `ui_in` and presents `spike_out` and `vmem_out` on `uo_out`/`uio_out`. Each timestep runs a small sequencer: leak, serial accumulate over inputs, then threshold/fire.

Parameters:
N_IN, 8, number of input spike lines
N_OUT, 4, number of neurons
W_BITS, 4, signed weight width
V_BITS, 8, signed membrane potential width
LEAK_SHIFT, 3, leak = v >>> LEAK_SHIFT per timestep
REFRAC, 2, refractory length in timesteps after a spike

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
spike_in  in  N_IN  input spike vector, sampled on accepted step
step  in  1  timestep strobe, one-cycle pulse
thr  in  V_BITS-1  firing threshold, unsigned, zero-extended to signed V_BITS
cfg_en  in  1  weight-load enable
cfg_bit  in  1  serial weight data
vmem_sel  in  clog2(N_OUT)  neuron selected for debug readout
spike_out  out  N_OUT  registered spike vector from last FIRE
busy  out  1  high while a timestep is in progress
vmem_out  out  V_BITS  combinational v[vmem_sel]

Behaviour:
- Reset (rst_n low, async) clears: all weights, all v, all refrac counters, spike_out, busy, state=IDLE. Reset mid-timestep aborts with no partial update visible.
- States: IDLE, LEAK, ACCUM, FIRE.
- IDLE with cfg_en=1: each clock shifts cfg_bit into a chain of N_IN*N_OUT*W_BITS bits (128 by default).
  - cfg_bit enters the MSB and the chain shifts right.
  - w[n][i] = chain[(n*N_IN+i)*W_BITS +: W_BITS], signed two's complement.
  - The first bit shifted in ends at chain bit 0 after a full load.
- IDLE, cfg_en=0, step=1: latch spike_in into spk_r, busy<=1, go to LEAK. step with cfg_en=1 in the same cycle is dropped; cfg wins.
- step while busy is ignored, with no queuing. cfg_en while busy is ignored, and the chain is unchanged.
- LEAK (1 cycle): for each non-refractory neuron, v <= v - (v >>> LEAK_SHIFT), using an arithmetic shift. This gives 7->7, 14->13, -1->0, -64->-56. Then go to ACCUM with idx=0.
- ACCUM (N_IN cycles, idx 0..N_IN-1):
  - If spk_r[idx]=1, each non-refractory neuron does v <= sat(v + sext(w[n][idx])).
  - sat clamps to [-2^(V_BITS-1), 2^(V_BITS-1)-1], i.e. [-128,127]. Saturation is applied after every addition.
  - At idx=N_IN-1, go to FIRE.
- FIRE (1 cycle), per neuron:
  - refrac>0: refrac<=refrac-1, spike_out[n]<=0, v stays 0.
  - else if v >= thr (signed compare): spike_out[n]<=1, v<=0, refrac<=REFRAC.
  - else: spike_out[n]<=0.
  - busy<=0, state<=IDLE.
- Latency: with step sampled at edge k, spike_out updates at edge k+N_IN+2 (k+10 by default). busy is high from edge k through edge k+N_IN+2, exclusive. spike_out holds until the next FIRE.
- Refractory neurons skip both LEAK and ACCUM. A neuron firing on timestep t next accumulates on timestep t+REFRAC+1.
- thr=0: any v>=0 fires, including v=0 with no input.

Test Plan:
- Reset, then release -> spike_out=0, busy=0, vmem_out=0 for every vmem_sel; step with spike_in=0xFF and all weights 0, thr=1 -> spike_out=0.
- Load w[0][*]=+3, others 0, thr=10; steps with spike_in=0xFF -> step1 spike_out=4'b0001 exactly 10 edges after step; steps 2,3 spike_out=0 (refractory); step4 fires again; v0=0 after each fire.
- w[1][0]=+7, thr=100; spike_in=0x01 twice then 0x00 once -> vmem_out(sel=1)=7, then 14, then 13.
- w[2][*]=-8, thr=100; three steps of spike_in=0xFF -> vmem_out(sel=2)=-64 (0xC0), -120 (0x88), -128 (0x80, saturated).
- step pulsed while busy, and cfg_en toggled while busy -> no second timestep, weights unchanged; step+cfg_en same cycle in IDLE -> busy stays 0, one bit shifted.
- rst_n low during ACCUM idx=4 -> busy=0, all v=0, spike_out=0 immediately (async); next step after release behaves as fresh with weights=0.
